// File: rtl/tdm_sched_pkg.sv
// Shared types and the round-robin search helper for the TDM slot scheduler.
//   state_t : scheduler FSM states
//   pick_t  : result of a round-robin search {found, idx}
//   rr_pick : first set request at or after 'start' (mod n)
package tdm_sched_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam int unsigned MAX_REQ = 32;
  localparam int unsigned PICK_W  = $clog2(MAX_REQ);

  typedef struct packed {
    logic              found;
    logic [PICK_W-1:0] idx;
  } pick_t;

  // Circular search over the low n bits of req, beginning at index start mod n.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                    input int unsigned        n,
                                    input int unsigned        start);
    pick_t             res;
    logic [PICK_W-1:0] k;
    res = '0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      if (i < n && !res.found) begin
        k = PICK_W'((start + i) % n);
        if (req[k]) begin
          res.found = 1'b1;
          res.idx   = k;
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/slot_timer.sv
// Mod-N slot timer.
//   clk, reset_n : clock, synchronous active-low reset
//   clear        : synchronous clear to 0, wins over enable
//   enable       : advance the count by one (wraps N-1 -> 0)
//   count        : current count, 0..N-1 (registered)
//   tc           : terminal count, high when count == N-1
module slot_timer #(
  parameter int unsigned N = 10,
  parameter int unsigned W = $clog2(N)
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clear,
  input  logic         enable,
  output logic [W-1:0] count,
  output logic         tc
);

  logic [W-1:0] r_count;

  // Explicit wrap at N-1 keeps non-power-of-two lengths in range.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable) begin
      r_count <= tc ? '0 : r_count + W'(1);
    end
  end

  assign count = r_count;
  assign tc    = (r_count == W'(N - 1));

endmodule

// File: rtl/tdm_slot_scheduler.sv
// Time-division round-robin scheduler sharing one resource among NREQ agents.
//   clk, reset_n : clock, synchronous active-low reset
//   enable       : global advance; low freezes timer, grant and pointer
//   req          : level requests, held high while using the resource
//   gnt          : one-hot grant, registered (0 when idle)
//   gnt_id       : index of granted requester, registered (0 when idle)
//   gnt_vld      : any grant active, registered
//   slot_cnt     : cycles elapsed in the current slot
//   slot_end     : combinational pulse on the last active cycle of a grant
module tdm_slot_scheduler
  import tdm_sched_pkg::*;
#(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned SLOT_LEN = 10,
  parameter int unsigned SW       = $clog2(SLOT_LEN),
  parameter int unsigned IW       = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            enable,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   gnt_id,
  output logic            gnt_vld,
  output logic [SW-1:0]   slot_cnt,
  output logic            slot_end
);

  state_t          r_state, w_state_nxt;
  logic [NREQ-1:0] r_gnt, w_gnt_nxt;
  logic [IW-1:0]   r_gnt_id, w_gnt_id_nxt;
  logic            r_gnt_vld, w_gnt_vld_nxt;
  logic [IW-1:0]   r_ptr, w_ptr_nxt;

  logic            w_tc;
  logic            w_slot_end;
  logic            w_timer_clr;
  logic            w_timer_en;
  logic [IW-1:0]   w_search_base;
  pick_t           w_pick;
  logic            w_pick_ok;
  logic [IW-1:0]   w_pick_idx;

  slot_timer #(
    .N (SLOT_LEN),
    .W (SW)
  ) u_slot_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (w_timer_clr),
    .enable  (w_timer_en),
    .count   (slot_cnt),
    .tc      (w_tc)
  );

  // State, grant and pointer registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_gnt     <= '0;
      r_gnt_id  <= '0;
      r_gnt_vld <= 1'b0;
      r_ptr     <= IW'(NREQ - 1);
    end else begin
      r_state   <= w_state_nxt;
      r_gnt     <= w_gnt_nxt;
      r_gnt_id  <= w_gnt_id_nxt;
      r_gnt_vld <= w_gnt_vld_nxt;
      r_ptr     <= w_ptr_nxt;
    end
  end

  // Next-state, next-grant and timer control.
  always_comb begin
    w_state_nxt   = r_state;
    w_gnt_nxt     = r_gnt;
    w_gnt_id_nxt  = r_gnt_id;
    w_gnt_vld_nxt = r_gnt_vld;
    w_ptr_nxt     = r_ptr;

    // Slot ends on expiry or when the owner lets go; frozen while disabled.
    w_slot_end = (r_state == GRANT) && enable && (w_tc || !req[r_gnt_id]);

    // While granting, the search starts after the current owner, so a sole
    // requester whose slot expired wraps around and is picked again.
    w_search_base = (r_state == GRANT) ? r_gnt_id : r_ptr;
    w_pick        = rr_pick(MAX_REQ'(req), NREQ, 32'(w_search_base) + 32'd1);
    w_pick_ok     = w_pick.found && (w_pick.idx < PICK_W'(NREQ));
    w_pick_idx    = IW'(w_pick.idx);

    unique case (r_state)
      IDLE: begin
        if (enable && w_pick_ok) begin
          w_state_nxt   = GRANT;
          w_gnt_nxt     = NREQ'(1) << w_pick_idx;
          w_gnt_id_nxt  = w_pick_idx;
          w_gnt_vld_nxt = 1'b1;
        end
      end
      GRANT: begin
        if (w_slot_end) begin
          w_ptr_nxt = r_gnt_id;
          if (w_pick_ok) begin
            w_gnt_nxt    = NREQ'(1) << w_pick_idx;
            w_gnt_id_nxt = w_pick_idx;
          end else begin
            w_state_nxt   = IDLE;
            w_gnt_nxt     = '0;
            w_gnt_id_nxt  = '0;
            w_gnt_vld_nxt = 1'b0;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    // Timer sits at 0 in IDLE and restarts on every slot boundary.
    w_timer_clr = (r_state == IDLE) || w_slot_end;
    w_timer_en  = enable && (r_state == GRANT);
  end

  assign gnt      = r_gnt;
  assign gnt_id   = r_gnt_id;
  assign gnt_vld  = r_gnt_vld;
  assign slot_end = w_slot_end;

endmodule

// File: tb/tb_tdm_slot_scheduler.sv
// Self-checking bench for tdm_slot_scheduler (NREQ=4, SLOT_LEN=10).
// A reference model predicts every cycle; predictions go through a queue
// and are compared when the DUT output is sampled.
module tb_tdm_slot_scheduler;

  localparam int unsigned NREQ     = 4;
  localparam int unsigned SLOT_LEN = 10;

  logic       clk;
  logic       reset_n;
  logic       enable;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_vld;
  logic [3:0] slot_cnt;
  logic       slot_end;

  tdm_slot_scheduler #(
    .NREQ     (NREQ),
    .SLOT_LEN (SLOT_LEN)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .enable   (enable),
    .req      (req),
    .gnt      (gnt),
    .gnt_id   (gnt_id),
    .gnt_vld  (gnt_vld),
    .slot_cnt (slot_cnt),
    .slot_end (slot_end)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  typedef struct {
    logic       is_end;
    logic       send;
    logic [3:0] gnt;
    logic [1:0] id;
    logic       vld;
    logic [3:0] cnt;
  } exp_t;

  exp_t sb[$];

  // Reference model: owner (-1 = idle), time spent in slot, last finished owner.
  int m_owner = -1;
  int m_cnt   = 0;
  int m_ptr   = NREQ - 1;
  logic obs_end;

  function automatic int next_owner(input logic [3:0] r, input int after);
    for (int k = 1; k <= int'(NREQ); k++) begin
      if (r[(after + k) % NREQ]) return (after + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic step(input logic rn, input logic en, input logic [3:0] r);
    exp_t e;
    exp_t got;
    logic m_end;
    @(negedge clk);
    reset_n = rn;
    enable  = en;
    req     = r;
    m_end = en && (m_owner >= 0) && ((m_cnt == SLOT_LEN - 1) || !r[m_owner]);
    if (rn) begin
      e = '{is_end: 1'b1, send: m_end, gnt: 4'h0, id: 2'd0, vld: 1'b0, cnt: 4'h0};
      sb.push_back(e);
    end
    #1;
    obs_end = slot_end;
    if (rn) begin
      got = sb.pop_front();
      check("sb_kind_end", 32'(got.is_end), 32'd1);
      check("slot_end", 32'(slot_end), 32'(got.send));
    end
    // Advance the model to the state expected after this edge.
    if (!rn) begin
      m_owner = -1;
      m_cnt   = 0;
      m_ptr   = NREQ - 1;
    end else if (en) begin
      if (m_owner < 0) begin
        m_owner = next_owner(r, m_ptr);
        m_cnt   = 0;
      end else if (m_end) begin
        m_ptr   = m_owner;
        m_owner = next_owner(r, m_owner);
        m_cnt   = 0;
      end else begin
        m_cnt = m_cnt + 1;
      end
    end
    e.is_end = 1'b0;
    e.send   = 1'b0;
    e.gnt    = (m_owner < 0) ? 4'h0 : 4'(4'b0001 << m_owner);
    e.id     = (m_owner < 0) ? 2'd0 : 2'(m_owner);
    e.vld    = (m_owner >= 0);
    e.cnt    = 4'(m_cnt);
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    check("sb_kind_state", 32'(got.is_end), 32'd0);
    check("gnt",      32'(gnt),      32'(got.gnt));
    check("gnt_id",   32'(gnt_id),   32'(got.id));
    check("gnt_vld",  32'(gnt_vld),  32'(got.vld));
    check("slot_cnt", 32'(slot_cnt), 32'(got.cnt));
    check("onehot0",  32'($onehot0(gnt)), 32'd1);
    check("vld_or",   32'(gnt_vld), 32'(|gnt));
    check("gnt_at_id", 32'(gnt[gnt_id]), 32'(gnt_vld));
  endtask

  int ids[$];
  int n_end;
  logic drop_seen;
  logic [3:0] rr;
  logic en_r;
  logic rn_r;

  initial begin
    reset_n = 1'b0;
    enable  = 1'b1;
    req     = 4'b1111;

    // 1. reset held 3 cycles with all requests up
    repeat (3) step(1'b0, 1'b1, 4'b1111);
    check("t1_rst_gnt", 32'(gnt), 32'h0);
    check("t1_rst_cnt", 32'(slot_cnt), 32'h0);
    step(1'b1, 1'b1, 4'b1111);
    check("t1_first_gnt", 32'(gnt), 32'h1);

    // 2. full rotation with all requests held
    n_end = 0;
    for (int c = 0; c < 40; c++) begin
      step(1'b1, 1'b1, 4'b1111);
      n_end += int'(obs_end);
      if (slot_cnt == 4'd0) ids.push_back(int'(gnt_id));
    end
    check("t2_nslots", 32'(ids.size()), 32'd4);
    check("t2_id0", 32'(ids[0]), 32'd1);
    check("t2_id1", 32'(ids[1]), 32'd2);
    check("t2_id2", 32'(ids[2]), 32'd3);
    check("t2_id3", 32'(ids[3]), 32'd0);
    check("t2_nend", 32'(n_end), 32'd4);

    // 3. requester 1 releases early at slot_cnt 3
    repeat (10) step(1'b1, 1'b1, 4'b1111);
    check("t3_owner1", 32'(gnt), 32'h2);
    repeat (3) step(1'b1, 1'b1, 4'b1111);
    check("t3_cnt3", 32'(slot_cnt), 32'd3);
    step(1'b1, 1'b1, 4'b1101);
    check("t3_end", 32'(obs_end), 32'd1);
    check("t3_gnt2", 32'(gnt), 32'h4);
    check("t3_cnt0", 32'(slot_cnt), 32'd0);

    // 4. single requester keeps being re-granted, then releases
    drop_seen = 1'b0;
    for (int c = 0; c < 25; c++) begin
      step(1'b1, 1'b1, 4'b0100);
      if (gnt != 4'b0100) drop_seen = 1'b1;
    end
    check("t4_no_drop", 32'(drop_seen), 32'd0);
    step(1'b1, 1'b1, 4'b0000);
    check("t4_idle_gnt", 32'(gnt), 32'h0);
    check("t4_idle_vld", 32'(gnt_vld), 32'd0);

    // 5. enable low for 5 cycles at slot_cnt 6
    step(1'b1, 1'b1, 4'b1111);
    check("t5_gnt3", 32'(gnt), 32'h8);
    repeat (6) step(1'b1, 1'b1, 4'b1111);
    check("t5_cnt6", 32'(slot_cnt), 32'd6);
    n_end = 0;
    for (int c = 0; c < 5; c++) begin
      step(1'b1, 1'b0, 4'b1111);
      n_end += int'(obs_end);
    end
    check("t5_hold_cnt", 32'(slot_cnt), 32'd6);
    check("t5_hold_gnt", 32'(gnt), 32'h8);
    check("t5_no_end", 32'(n_end), 32'd0);
    repeat (3) step(1'b1, 1'b1, 4'b1111);
    check("t5_cnt9", 32'(slot_cnt), 32'd9);
    step(1'b1, 1'b1, 4'b1111);
    check("t5_end", 32'(obs_end), 32'd1);
    check("t5_next", 32'(gnt), 32'h1);

    // 6. reset mid-grant restores requester 0 priority
    repeat (10) step(1'b1, 1'b1, 4'b1111);
    repeat (4) step(1'b1, 1'b1, 4'b1111);
    check("t6_pre", 32'(gnt), 32'h2);
    check("t6_cnt4", 32'(slot_cnt), 32'd4);
    step(1'b0, 1'b1, 4'b1111);
    check("t6_rst_gnt", 32'(gnt), 32'h0);
    check("t6_rst_cnt", 32'(slot_cnt), 32'd0);
    step(1'b1, 1'b1, 4'b1111);
    check("t6_prio0", 32'(gnt), 32'h1);

    // Random traffic against the model
    rr = 4'b1010;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) rr = 4'($urandom_range(0, 15));
      en_r = ($urandom_range(0, 4) != 0);
      rn_r = ($urandom_range(0, 60) != 0);
      step(rn_r, en_r, rr);
    end

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
